int_trap_sequencer: RTL

- Interrupt/MRET sequencer directly upstream of the integer pipeline controller; produces its `interrupt` and `mret_type` inputs.
- Watches level-sensitive machine interrupt lines and the MEM-stage instruction, and picks a precise squash point.
- Issues a one-cycle flush/redirect pulse with CSR write strobes (mepc/mcause/mstatus), then holds off new traps while the pipeline refills.

---
 rtl/int_trap_pkg.sv | 19 +
 rtl/int_trap_sequencer_if.sv | 39 +++
 rtl/int_irq_priority.sv | 30 +++
 rtl/int_trap_sequencer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/int_trap_pkg.sv
// Shared types and constants for the interrupt/MRET trap sequencer.
package int_trap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRefill
  } trap_state_e;

  localparam logic [3:0] CauseMei = 4'd11;
  localparam logic [3:0] CauseMsi = 4'd3;
  localparam logic [3:0] CauseMti = 4'd7;

  // mcause interrupt flag sits in the top bit of the datapath
  function automatic int unsigned mcause_int_bit(int unsigned xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/int_trap_sequencer_if.sv
// Bundle of interrupt inputs, MEM-stage status and trap/CSR outputs of the sequencer.
interface int_trap_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            irq_ext;
  logic            irq_sw;
  logic            irq_timer;
  logic [2:0]      mie_bits;
  logic            mstatus_mie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc_csr;
  logic            valid_mem;
  logic [XLEN-1:0] pc_mem;
  logic            mret_mem;
  logic            stall_pipl;

  logic            interrupt;
  logic            mret_type;
  logic [XLEN-1:0] redirect_pc;
  logic            csr_trap_we;
  logic [XLEN-1:0] csr_mepc_wdata;
  logic [XLEN-1:0] csr_mcause_wdata;
  logic            csr_mret_we;
  logic            busy;

  modport master (
    input  irq_ext, irq_sw, irq_timer, mie_bits, mstatus_mie, mtvec, mepc_csr,
    input  valid_mem, pc_mem, mret_mem, stall_pipl,
    output interrupt, mret_type, redirect_pc, csr_trap_we, csr_mepc_wdata,
    output csr_mcause_wdata, csr_mret_we, busy
  );

  modport slave (
    output irq_ext, irq_sw, irq_timer, mie_bits, mstatus_mie, mtvec, mepc_csr,
    output valid_mem, pc_mem, mret_mem, stall_pipl,
    input  interrupt, mret_type, redirect_pc, csr_trap_we, csr_mepc_wdata,
    input  csr_mcause_wdata, csr_mret_we, busy
  );
endinterface

// File: rtl/int_irq_priority.sv
// Masked 3-source machine interrupt priority encoder: ext > sw > timer.
module int_irq_priority
  import int_trap_pkg::*;
(
  input  logic       irq_ext_i,
  input  logic       irq_sw_i,
  input  logic       irq_timer_i,
  input  logic [2:0] mie_bits_i,
  input  logic       mstatus_mie_i,
  output logic       pend_o,
  output logic [3:0] cause_o
);

  logic [2:0] masked;

  assign masked = {irq_ext_i, irq_sw_i, irq_timer_i} & mie_bits_i;
  assign pend_o = (|masked) & mstatus_mie_i;

  always_comb begin
    cause_o = 4'd0;
    if (masked[2]) begin
      cause_o = CauseMei;
    end else if (masked[1]) begin
      cause_o = CauseMsi;
    end else if (masked[0]) begin
      cause_o = CauseMti;
    end
  end

endmodule

// File: rtl/int_trap_sequencer.sv
// Interrupt/MRET sequencer: picks a precise MEM-stage squash point and pulses redirect + CSR strobes.
// Optional macro INT_TRAP_VECTORED_EN enables vectored mtvec (mode 2'b01) targets.
module int_trap_sequencer
  import int_trap_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned REFILL_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  int_trap_sequencer_if.master bus_io
);

  localparam int unsigned McauseIntBit = mcause_int_bit(XLEN);
  localparam logic [3:0]  RefillInit   = 4'(REFILL_CYCLES - 1);

  trap_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic       pend;
  logic [3:0] cause;
  logic       take_ok;
  logic       trap_fire;
  logic       mret_fire;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;

  int_irq_priority u_prio (
    .irq_ext_i     (bus_io.irq_ext),
    .irq_sw_i      (bus_io.irq_sw),
    .irq_timer_i   (bus_io.irq_timer),
    .mie_bits_i    (bus_io.mie_bits),
    .mstatus_mie_i (bus_io.mstatus_mie),
    .pend_o        (pend),
    .cause_o       (cause)
  );

  // Bubbles and stalled slots carry no precise PC, so never act on them.
  assign take_ok = bus_io.valid_mem & ~bus_io.stall_pipl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    trap_fire = 1'b0;
    mret_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend) begin
          state_d = StArm;
        end else if (bus_io.mret_mem && take_ok) begin
          mret_fire = 1'b1;
          state_d   = StRefill;
          cnt_d     = RefillInit;
        end
      end
      StArm: begin
        // MRET wins; the still-pending interrupt is re-evaluated after refill.
        if (bus_io.mret_mem && take_ok) begin
          mret_fire = 1'b1;
          state_d   = StRefill;
          cnt_d     = RefillInit;
        end else if (!pend) begin
          state_d = StIdle;
        end else if (take_ok) begin
          trap_fire = 1'b1;
          state_d   = StRefill;
          cnt_d     = RefillInit;
        end
      end
      StRefill: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign trap_base = {bus_io.mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    trap_target = trap_base;
`ifdef INT_TRAP_VECTORED_EN
    if (bus_io.mtvec[1:0] == 2'b01) begin
      trap_target = trap_base + (XLEN'(cause) << 2);
    end
`endif
  end

  always_comb begin
    bus_io.interrupt        = 1'b0;
    bus_io.mret_type        = 1'b0;
    bus_io.redirect_pc      = '0;
    bus_io.csr_trap_we      = 1'b0;
    bus_io.csr_mepc_wdata   = '0;
    bus_io.csr_mcause_wdata = '0;
    bus_io.csr_mret_we      = 1'b0;
    bus_io.busy             = 1'b0;
    if (!reset) begin
      bus_io.busy = (state_q != StIdle);
      if (trap_fire) begin
        bus_io.interrupt                      = 1'b1;
        bus_io.csr_trap_we                    = 1'b1;
        bus_io.redirect_pc                    = trap_target;
        bus_io.csr_mepc_wdata                 = bus_io.pc_mem;
        bus_io.csr_mcause_wdata[3:0]          = cause;
        bus_io.csr_mcause_wdata[McauseIntBit] = 1'b1;
      end else if (mret_fire) begin
        bus_io.mret_type   = 1'b1;
        bus_io.csr_mret_we = 1'b1;
        bus_io.redirect_pc = bus_io.mepc_csr;
      end
    end
  end

endmodule
